axis_ctrl_reg: RTL and testbench

- AXI4-Lite slave control/status register block; sits directly upstream of the DDR-to-RAM AXI master control stage.
- Host software programs the base address and length, then starts the job.
- Block drives the level `ap_start`, plus the shadowed base address and length, into the downstream stage.
- It captures the downstream `ap_done`/`ap_ready` pulses into readable status and an interrupt.

---
 rtl/axis_ctrl_reg_pkg.sv | 43 ++++
 rtl/axis_ctrl_reg.sv | 240 ++++++++++++++++++++++++
 tb/tb_axis_ctrl_reg.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_ctrl_reg_pkg.sv
// Shared definitions for the axis_ctrl_reg AXI4-Lite control/status block:
// register offsets, CTRL bit positions, channel FSM encodings and a byte-strobe helper.
package axis_ctrl_reg_pkg;

    localparam logic [7:0] ADDR_CTRL = 8'h00;
    localparam logic [7:0] ADDR_GIE  = 8'h04;
    localparam logic [7:0] ADDR_IER  = 8'h08;
    localparam logic [7:0] ADDR_ISR  = 8'h0C;
    localparam logic [7:0] ADDR_BASE = 8'h10;
    localparam logic [7:0] ADDR_LEN  = 8'h18;

    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_IDLE  = 2;
    localparam int CTRL_READY = 3;
    localparam int CTRL_AUTO  = 7;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // Merge a 32-bit write into an existing value under the AXI byte strobes.
    function automatic logic [31:0] applyStrb(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  strb);
        logic [31:0] res;
        res = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = newVal[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_ctrl_reg.sv
// AXI4-Lite control/status registers driving ap_start and shadowed base/len downstream.
// Define AXIS_CTRL_REG_IRQ_EN to add GIE/IER/ISR and the O_interrupt output.
module axis_ctrl_reg
    import axis_ctrl_reg_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            I_clk,
    input  logic                            I_rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   I_saxi_awaddr,
    input  logic                            I_saxi_awvalid,
    output logic                            O_saxi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   I_saxi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] I_saxi_wstrb,
    input  logic                            I_saxi_wvalid,
    output logic                            O_saxi_wready,
    output logic [1:0]                      O_saxi_bresp,
    output logic                            O_saxi_bvalid,
    input  logic                            I_saxi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   I_saxi_araddr,
    input  logic                            I_saxi_arvalid,
    output logic                            O_saxi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   O_saxi_rdata,
    output logic [1:0]                      O_saxi_rresp,
    output logic                            O_saxi_rvalid,
    input  logic                            I_saxi_rready,
    output logic                            O_ap_start,
    input  logic                            I_ap_done,
    input  logic                            I_ap_ready,
    output logic [27:0]                     O_base_addr,
    output logic [31:0]                     O_len
`ifdef AXIS_CTRL_REG_IRQ_EN
    ,
    output logic                            O_interrupt
`endif
);

    // Byte-address match ignoring the two sub-word bits.
    function automatic logic isAddr(input logic [C_S_AXI_ADDR_WIDTH-1:0] a,
                                    input logic [7:0] off);
        return (a & ~C_S_AXI_ADDR_WIDTH'(3)) == C_S_AXI_ADDR_WIDTH'(off);
    endfunction

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0] rdata_q, rdata_d, rdataSel;
    logic        apStart_q, apStart_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        autoRestart_q, autoRestart_d;
    logic [27:0] base_q, base_d, baseShadow_q, baseShadow_d;
    logic [31:0] len_q, len_d, lenShadow_q, lenShadow_d;
    logic [31:0] baseMerged;
    logic        unused_bits;

    logic wHs, arHs, wrCtrl, wrBase, wrLen, rdCtrl, startSet, restart;

`ifdef AXIS_CTRL_REG_IRQ_EN
    logic       gie_q, gie_d;
    logic [1:0] ier_q, ier_d;
    logic [1:0] isr_q, isr_d;
    logic       irq_q, irq_d;
    logic       wrGie, wrIer, wrIsr;

    assign wrGie       = wHs && isAddr(awaddr_q, ADDR_GIE);
    assign wrIer       = wHs && isAddr(awaddr_q, ADDR_IER);
    assign wrIsr       = wHs && isAddr(awaddr_q, ADDR_ISR);
    assign O_interrupt = irq_q;
`endif

    assign wHs      = (wstate_q == W_DATA) && I_saxi_wvalid;
    assign arHs     = (rstate_q == R_IDLE) && I_saxi_arvalid;
    assign wrCtrl   = wHs && isAddr(awaddr_q, ADDR_CTRL);
    assign wrBase   = wHs && isAddr(awaddr_q, ADDR_BASE);
    assign wrLen    = wHs && isAddr(awaddr_q, ADDR_LEN);
    assign rdCtrl   = arHs && isAddr(I_saxi_araddr, ADDR_CTRL);
    assign startSet = wrCtrl && I_saxi_wstrb[0] && I_saxi_wdata[CTRL_START] && !apStart_q;
    assign restart  = I_ap_ready && apStart_q && autoRestart_q;

    assign baseMerged  = applyStrb({4'h0, base_q}, I_saxi_wdata, I_saxi_wstrb);
    assign unused_bits = ^baseMerged[31:28];

    assign O_saxi_bresp = RESP_OKAY;
    assign O_saxi_rresp = RESP_OKAY;
    assign O_saxi_rdata = rdata_q;
    assign O_ap_start   = apStart_q;
    assign O_base_addr  = baseShadow_q;
    assign O_len        = lenShadow_q;

    always_comb begin
        wstate_d       = wstate_q;
        O_saxi_awready = 1'b0;
        O_saxi_wready  = 1'b0;
        O_saxi_bvalid  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                O_saxi_awready = 1'b1;
                if (I_saxi_awvalid) wstate_d = W_DATA;
            end
            W_DATA: begin
                O_saxi_wready = 1'b1;
                if (I_saxi_wvalid) wstate_d = W_RESP;
            end
            W_RESP: begin
                O_saxi_bvalid = 1'b1;
                if (I_saxi_bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d       = rstate_q;
        O_saxi_arready = 1'b0;
        O_saxi_rvalid  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                O_saxi_arready = 1'b1;
                if (I_saxi_arvalid) rstate_d = R_DATA;
            end
            R_DATA: begin
                O_saxi_rvalid = 1'b1;
                if (I_saxi_rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read data reflects register contents before any clear-on-read takes effect.
    always_comb begin
        rdataSel = '0;
        if (isAddr(I_saxi_araddr, ADDR_CTRL)) begin
            rdataSel[CTRL_START] = apStart_q;
            rdataSel[CTRL_DONE]  = done_q;
            rdataSel[CTRL_IDLE]  = ~apStart_q;
            rdataSel[CTRL_READY] = ready_q;
            rdataSel[CTRL_AUTO]  = autoRestart_q;
        end
        if (isAddr(I_saxi_araddr, ADDR_BASE)) rdataSel = {4'h0, base_q};
        if (isAddr(I_saxi_araddr, ADDR_LEN))  rdataSel = len_q;
`ifdef AXIS_CTRL_REG_IRQ_EN
        if (isAddr(I_saxi_araddr, ADDR_GIE)) rdataSel = {31'h0, gie_q};
        if (isAddr(I_saxi_araddr, ADDR_IER)) rdataSel = {30'h0, ier_q};
        if (isAddr(I_saxi_araddr, ADDR_ISR)) rdataSel = {30'h0, isr_q};
`endif
    end

    // Register file next state; hardware set events take priority over host clears/toggles.
    always_comb begin
        awaddr_d      = awaddr_q;
        rdata_d       = rdata_q;
        apStart_d     = apStart_q;
        done_d        = done_q;
        ready_d       = ready_q;
        autoRestart_d = autoRestart_q;
        base_d        = base_q;
        len_d         = len_q;
        baseShadow_d  = baseShadow_q;
        lenShadow_d   = lenShadow_q;

        if ((wstate_q == W_IDLE) && I_saxi_awvalid) awaddr_d = I_saxi_awaddr;
        if (arHs) rdata_d = rdataSel;

        if (wrCtrl && I_saxi_wstrb[0]) autoRestart_d = I_saxi_wdata[CTRL_AUTO];
        if (wrBase) base_d = baseMerged[27:0];
        if (wrLen)  len_d  = applyStrb(len_q, I_saxi_wdata, I_saxi_wstrb);

        if (I_ap_ready && !autoRestart_q) apStart_d = 1'b0;
        if (startSet) apStart_d = 1'b1;
        if (startSet || restart) begin
            baseShadow_d = base_q;
            lenShadow_d  = len_q;
        end

        if (rdCtrl) begin
            done_d  = 1'b0;
            ready_d = 1'b0;
        end
        if (I_ap_done)  done_d  = 1'b1;
        if (I_ap_ready) ready_d = 1'b1;

`ifdef AXIS_CTRL_REG_IRQ_EN
        gie_d = gie_q;
        ier_d = ier_q;
        isr_d = isr_q;
        irq_d = gie_q & (|isr_q);
        if (wrGie && I_saxi_wstrb[0]) gie_d = I_saxi_wdata[0];
        if (wrIer && I_saxi_wstrb[0]) ier_d = I_saxi_wdata[1:0];
        if (wrIsr && I_saxi_wstrb[0]) isr_d = isr_q ^ I_saxi_wdata[1:0];
        if (I_ap_done  && ier_q[0]) isr_d[0] = 1'b1;
        if (I_ap_ready && ier_q[1]) isr_d[1] = 1'b1;
`endif
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wstate_q      <= W_IDLE;
            rstate_q      <= R_IDLE;
            awaddr_q      <= '0;
            rdata_q       <= '0;
            apStart_q     <= 1'b0;
            done_q        <= 1'b0;
            ready_q       <= 1'b0;
            autoRestart_q <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            baseShadow_q  <= '0;
            lenShadow_q   <= '0;
`ifdef AXIS_CTRL_REG_IRQ_EN
            gie_q         <= 1'b0;
            ier_q         <= '0;
            isr_q         <= '0;
            irq_q         <= 1'b0;
`endif
        end else begin
            wstate_q      <= wstate_d;
            rstate_q      <= rstate_d;
            awaddr_q      <= awaddr_d;
            rdata_q       <= rdata_d;
            apStart_q     <= apStart_d;
            done_q        <= done_d;
            ready_q       <= ready_d;
            autoRestart_q <= autoRestart_d;
            base_q        <= base_d;
            len_q         <= len_d;
            baseShadow_q  <= baseShadow_d;
            lenShadow_q   <= lenShadow_d;
`ifdef AXIS_CTRL_REG_IRQ_EN
            gie_q         <= gie_d;
            ier_q         <= ier_d;
            isr_q         <= isr_d;
            irq_q         <= irq_d;
`endif
        end
    end

endmodule

// File: tb/tb_axis_ctrl_reg.sv
// Self-checking bench for axis_ctrl_reg: directed register-map scenarios plus
// randomized AXI-Lite traffic compared against a transaction-level register model.
module tb_axis_ctrl_reg;

    localparam int BUDGET = 50;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic [5:0]  I_saxi_awaddr;
    logic        I_saxi_awvalid;
    logic        O_saxi_awready;
    logic [31:0] I_saxi_wdata;
    logic [3:0]  I_saxi_wstrb;
    logic        I_saxi_wvalid;
    logic        O_saxi_wready;
    logic [1:0]  O_saxi_bresp;
    logic        O_saxi_bvalid;
    logic        I_saxi_bready;
    logic [5:0]  I_saxi_araddr;
    logic        I_saxi_arvalid;
    logic        O_saxi_arready;
    logic [31:0] O_saxi_rdata;
    logic [1:0]  O_saxi_rresp;
    logic        O_saxi_rvalid;
    logic        I_saxi_rready;
    logic        O_ap_start;
    logic        I_ap_done;
    logic        I_ap_ready;
    logic [27:0] O_base_addr;
    logic [31:0] O_len;
`ifdef AXIS_CTRL_REG_IRQ_EN
    logic        O_interrupt;
`endif

    always #5 I_clk = ~I_clk;

    axis_ctrl_reg #(.C_S_AXI_ADDR_WIDTH(6), .C_S_AXI_DATA_WIDTH(32)) dut (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_saxi_awaddr(I_saxi_awaddr), .I_saxi_awvalid(I_saxi_awvalid), .O_saxi_awready(O_saxi_awready),
        .I_saxi_wdata(I_saxi_wdata), .I_saxi_wstrb(I_saxi_wstrb), .I_saxi_wvalid(I_saxi_wvalid),
        .O_saxi_wready(O_saxi_wready),
        .O_saxi_bresp(O_saxi_bresp), .O_saxi_bvalid(O_saxi_bvalid), .I_saxi_bready(I_saxi_bready),
        .I_saxi_araddr(I_saxi_araddr), .I_saxi_arvalid(I_saxi_arvalid), .O_saxi_arready(O_saxi_arready),
        .O_saxi_rdata(O_saxi_rdata), .O_saxi_rresp(O_saxi_rresp), .O_saxi_rvalid(O_saxi_rvalid),
        .I_saxi_rready(I_saxi_rready),
        .O_ap_start(O_ap_start), .I_ap_done(I_ap_done), .I_ap_ready(I_ap_ready),
        .O_base_addr(O_base_addr), .O_len(O_len)
`ifdef AXIS_CTRL_REG_IRQ_EN
        , .O_interrupt(O_interrupt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Behavioural register model, updated once per completed bus transaction or pulse.
    logic [27:0] mBase, mShBase;
    logic [31:0] mLen, mShLen;
    logic        mStart, mDone, mReady, mAuto, mGie;
    logic [1:0]  mIer, mIsr;
    logic        snapStart;
    logic [27:0] snapBase;
    logic [31:0] snapLen;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mBase = '0; mShBase = '0; mLen = '0; mShLen = '0;
        mStart = 0; mDone = 0; mReady = 0; mAuto = 0; mGie = 0; mIer = '0; mIsr = '0;
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = oldVal;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input logic [5:0] addr);
        logic [31:0] v;
        v = '0;
        case (addr)
            6'h00: v = {24'h0, mAuto, 3'b000, mReady, ~mStart, mDone, mStart};
            6'h10: v = {4'h0, mBase};
            6'h18: v = mLen;
`ifdef AXIS_CTRL_REG_IRQ_EN
            6'h04: v = {31'h0, mGie};
            6'h08: v = {30'h0, mIer};
            6'h0C: v = {30'h0, mIsr};
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic modelWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] tmp;
        case (addr)
            6'h00: if (strb[0]) begin
                mAuto = data[7];
                if (data[0] && !mStart) begin
                    mStart = 1; mShBase = mBase; mShLen = mLen;
                end
            end
`ifdef AXIS_CTRL_REG_IRQ_EN
            6'h04: if (strb[0]) mGie = data[0];
            6'h08: if (strb[0]) mIer = data[1:0];
            6'h0C: if (strb[0]) mIsr = mIsr ^ data[1:0];
`endif
            6'h10: begin tmp = mergeBytes({4'h0, mBase}, data, strb); mBase = tmp[27:0]; end
            6'h18: mLen = mergeBytes(mLen, data, strb);
            default: ;
        endcase
    endtask

    task automatic modelDone();
        mDone = 1;
`ifdef AXIS_CTRL_REG_IRQ_EN
        if (mIer[0]) mIsr[0] = 1;
`endif
    endtask

    task automatic modelReady();
        mReady = 1;
        if (mStart) begin
            if (mAuto) begin mShBase = mBase; mShLen = mLen; end
            else mStart = 0;
        end
`ifdef AXIS_CTRL_REG_IRQ_EN
        if (mIer[1]) mIsr[1] = 1;
`endif
    endtask

    task automatic axiWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge I_clk);
        I_saxi_awaddr = addr; I_saxi_awvalid = 1;
        n = 0;
        while (!O_saxi_awready && n < BUDGET) begin @(negedge I_clk); n++; end
        checkOutput("awTimeout", (n < BUDGET) ? 0 : 1, 0);
        @(negedge I_clk);
        I_saxi_awvalid = 0;
        I_saxi_wdata = data; I_saxi_wstrb = strb; I_saxi_wvalid = 1;
        n = 0;
        while (!O_saxi_wready && n < BUDGET) begin @(negedge I_clk); n++; end
        checkOutput("wTimeout", (n < BUDGET) ? 0 : 1, 0);
        @(negedge I_clk);
        I_saxi_wvalid = 0;
        snapStart = O_ap_start; snapBase = O_base_addr; snapLen = O_len;
        modelWrite(addr, data, strb);
        I_saxi_bready = 1;
        n = 0;
        while (!O_saxi_bvalid && n < BUDGET) begin @(negedge I_clk); n++; end
        checkOutput("bTimeout", (n < BUDGET) ? 0 : 1, 0);
        checkOutput("bresp", {30'h0, O_saxi_bresp}, 0);
        @(negedge I_clk);
        I_saxi_bready = 0;
    endtask

    // Read and compare against the model; optionally pulse ap_done on the ar handshake cycle.
    task automatic axiReadCheck(input string tag, input logic [5:0] addr, input logic pulseDone);
        int n;
        logic [31:0] exp;
        @(negedge I_clk);
        I_saxi_araddr = addr; I_saxi_arvalid = 1;
        if (pulseDone) I_ap_done = 1;
        n = 0;
        while (!O_saxi_arready && n < BUDGET) begin @(negedge I_clk); n++; end
        checkOutput("arTimeout", (n < BUDGET) ? 0 : 1, 0);
        exp = modelRead(addr);
        if (addr == 6'h00) begin mDone = 0; mReady = 0; end
        if (pulseDone) modelDone();
        @(negedge I_clk);
        I_saxi_arvalid = 0; I_ap_done = 0; I_saxi_rready = 1;
        n = 0;
        while (!O_saxi_rvalid && n < BUDGET) begin @(negedge I_clk); n++; end
        checkOutput("rTimeout", (n < BUDGET) ? 0 : 1, 0);
        checkOutput(tag, O_saxi_rdata, exp);
        checkOutput("rresp", {30'h0, O_saxi_rresp}, 0);
        @(negedge I_clk);
        I_saxi_rready = 0;
    endtask

    task automatic applyStimulus(input logic done, input logic ready);
        @(negedge I_clk);
        I_ap_done = done; I_ap_ready = ready;
        @(negedge I_clk);
        I_ap_done = 0; I_ap_ready = 0;
        if (done)  modelDone();
        if (ready) modelReady();
    endtask

    task automatic checkState();
        @(negedge I_clk);
        checkOutput("apStart", {31'h0, O_ap_start}, {31'h0, mStart});
        checkOutput("baseAddr", {4'h0, O_base_addr}, {4'h0, mShBase});
        checkOutput("len", O_len, mShLen);
`ifdef AXIS_CTRL_REG_IRQ_EN
        checkOutput("interrupt", {31'h0, O_interrupt}, {31'h0, mGie & (|mIsr)});
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0]  addrTab [10];
        logic [5:0]  a;
        logic [31:0] d, stallExp;
        int op;
        addrTab = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h18, 6'h14, 6'h1C, 6'h20, 6'h3C};

        I_rst = 1; I_saxi_awaddr = '0; I_saxi_awvalid = 0; I_saxi_wdata = '0; I_saxi_wstrb = '0;
        I_saxi_wvalid = 0; I_saxi_bready = 0; I_saxi_araddr = '0; I_saxi_arvalid = 0;
        I_saxi_rready = 0; I_ap_done = 0; I_ap_ready = 0;
        modelReset();
        repeat (3) @(negedge I_clk);
        I_rst = 0;

        // Reset state
        checkOutput("rstAwready", {31'h0, O_saxi_awready}, 1);
        checkOutput("rstArready", {31'h0, O_saxi_arready}, 1);
        checkOutput("rstBvalid", {31'h0, O_saxi_bvalid}, 0);
        checkOutput("rstRvalid", {31'h0, O_saxi_rvalid}, 0);
        checkOutput("rstRdata", O_saxi_rdata, 0);
        checkState();
        axiReadCheck("rstCtrl", 6'h00, 0);
        checkOutput("rstCtrlConst", O_saxi_rdata, 32'h4);

        // Basic job start and completion
        axiWrite(6'h10, 32'h0123456, 4'hF);
        axiWrite(6'h18, 32'h40, 4'hF);
        axiWrite(6'h00, 32'h1, 4'hF);
        checkOutput("startSnap", {31'h0, snapStart}, 1);
        checkOutput("baseSnap", {4'h0, snapBase}, 32'h0123456);
        checkOutput("lenSnap", snapLen, 32'h40);
        axiReadCheck("ctrlBusy", 6'h00, 0);
        applyStimulus(0, 1);
        checkState();
        checkOutput("startCleared", {31'h0, O_ap_start}, 0);

        // Clear-on-read of done/ready, including a set in the read cycle
        axiReadCheck("ctrlAfterReady", 6'h00, 0);
        applyStimulus(1, 0);
        axiReadCheck("ctrlDone", 6'h00, 0);
        axiReadCheck("ctrlDoneCleared", 6'h00, 0);
        axiReadCheck("ctrlRaceRead", 6'h00, 1);
        axiReadCheck("ctrlRaceKept", 6'h00, 0);
        axiReadCheck("ctrlRaceCleared", 6'h00, 0);

        // Auto-restart and shadowing of LEN
        axiWrite(6'h00, 32'h81, 4'hF);
        axiWrite(6'h18, 32'h80, 4'hF);
        checkOutput("lenHeld", O_len, 32'h40);
        checkState();
        applyStimulus(0, 1);
        checkState();
        checkOutput("lenReloaded", O_len, 32'h80);
        checkOutput("startKept", {31'h0, O_ap_start}, 1);
        axiWrite(6'h00, 32'h00, 4'hF);
        checkOutput("startW0", {31'h0, O_ap_start}, 1);
        applyStimulus(0, 1);
        checkState();
        axiReadCheck("unmapped14", 6'h14, 0);

        // Interrupt registers
        axiWrite(6'h04, 32'h1, 4'hF);
        axiWrite(6'h08, 32'h1, 4'hF);
        applyStimulus(1, 0);
        checkState();
`ifdef AXIS_CTRL_REG_IRQ_EN
        checkOutput("irqSet", {31'h0, O_interrupt}, 1);
`endif
        axiReadCheck("isrRead", 6'h0C, 0);
        axiWrite(6'h0C, 32'h1, 4'hF);
        checkState();
        axiReadCheck("gieRead", 6'h04, 0);
        axiReadCheck("ierRead", 6'h08, 0);

        // Back-pressure on B and R channels
        @(negedge I_clk);
        I_saxi_awaddr = 6'h18; I_saxi_awvalid = 1;
        @(negedge I_clk);
        I_saxi_awvalid = 0; I_saxi_wdata = 32'h5555_AAAA; I_saxi_wstrb = 4'hF; I_saxi_wvalid = 1;
        @(negedge I_clk);
        I_saxi_wvalid = 0;
        modelWrite(6'h18, 32'h5555_AAAA, 4'hF);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bStallValid", {31'h0, O_saxi_bvalid}, 1);
            checkOutput("bStallAw", {31'h0, O_saxi_awready}, 0);
            @(negedge I_clk);
        end
        I_saxi_bready = 1;
        @(negedge I_clk);
        I_saxi_bready = 0;
        checkOutput("bReleased", {31'h0, O_saxi_bvalid}, 0);
        stallExp = modelRead(6'h18);
        @(negedge I_clk);
        I_saxi_araddr = 6'h18; I_saxi_arvalid = 1;
        @(negedge I_clk);
        I_saxi_arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("rStallValid", {31'h0, O_saxi_rvalid}, 1);
            checkOutput("rStallData", O_saxi_rdata, stallExp);
            checkOutput("rStallAr", {31'h0, O_saxi_arready}, 0);
            @(negedge I_clk);
        end
        I_saxi_rready = 1;
        @(negedge I_clk);
        I_saxi_rready = 0;
        checkOutput("rReleased", {31'h0, O_saxi_rvalid}, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 5);
            a  = addrTab[$urandom_range(0, 9)];
            d  = $urandom;
            if (a == 6'h00) d = d & 32'h0000_0083;
            case (op)
                0, 1: axiWrite(a, d, 4'($urandom_range(0, 15)));
                2:    axiReadCheck("randRead", a, ($urandom_range(0, 3) == 0));
                3:    applyStimulus(1, 0);
                4:    applyStimulus(0, 1);
                default: applyStimulus(1, 1);
            endcase
            checkState();
        end

        // Reset in the middle of a write response
        @(negedge I_clk);
        I_saxi_awaddr = 6'h10; I_saxi_awvalid = 1;
        @(negedge I_clk);
        I_saxi_awvalid = 0; I_saxi_wdata = 32'h0FFF_FFFF; I_saxi_wstrb = 4'hF; I_saxi_wvalid = 1;
        @(negedge I_clk);
        I_saxi_wvalid = 0;
        checkOutput("midBvalid", {31'h0, O_saxi_bvalid}, 1);
        I_rst = 1;
        @(negedge I_clk);
        I_rst = 0;
        modelReset();
        checkOutput("midRstBvalid", {31'h0, O_saxi_bvalid}, 0);
        checkOutput("midRstAwready", {31'h0, O_saxi_awready}, 1);
        checkState();
        axiReadCheck("midRstBase", 6'h10, 0);
        axiReadCheck("midRstCtrl", 6'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
